// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared fetch-stage constants
package rv_fetch_pkg;
  localparam int FETCH_DATA_WIDTH = 32;
  localparam int FETCH_ROM_DEPTH = 256;
  localparam int FETCH_DEPTH = 2;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
endpackage

// File: rtl/rv_fetch_fifo.sv
// rv_fetch_fifo: generic synchronous FIFO with flush, head output holds last value when empty
module rv_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] last_q, last_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop = pop_i & ~empty_o;
  assign dout_o = empty_o ? last_q : mem_q[rd_q];
  // pointer/count/storage update; flush discards everything in flight
  always_comb begin
    mem_d = mem_q;
    if (do_push & ~flush_i) mem_d[wr_q] = din_i;
    wr_d = flush_i ? '0 : wr_q + PW'(do_push);
    rd_d = flush_i ? '0 : rd_q + PW'(do_pop);
    cnt_d = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    last_d = dout_o;
  end
  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      last_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: PC owner and fetch buffer feeding decode over valid/ready
module rv_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = FETCH_DATA_WIDTH,
  parameter int ROM_DEPTH = FETCH_ROM_DEPTH,
  parameter int FIFO_DEPTH = FETCH_DEPTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = FETCH_RESET_PC,
  localparam int AW = $clog2(ROM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [AW-1:0]         instr_addr_o,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic                  halt_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  if_valid_o,
  input  logic                  if_ready_i,
  output logic [DATA_WIDTH-1:0] if_instr_o,
  output logic [DATA_WIDTH-1:0] if_pc_o,
  output logic                  fetch_busy_o
);
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [2*DATA_WIDTH-1:0] head;
  logic full, empty, pop, push;
  assign instr_addr_o = pc_q[AW+1:2];
  assign if_valid_o = ~empty;
  assign pop = if_valid_o & if_ready_i;
  assign push = ~halt_i & ~redirect_i & (~full | pop);
  assign fetch_busy_o = ~empty | ~halt_i;
  assign {if_pc_o, if_instr_o} = head;
  // redirect wins; otherwise advance one word per accepted fetch
  always_comb pc_d = redirect_i ? (redirect_pc_i & ~DATA_WIDTH'(3)) : push ? pc_q + DATA_WIDTH'(4) : pc_q;
  // program counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  end
  rv_fetch_fifo #(.WIDTH(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(pop & ~redirect_i),
    .flush_i(redirect_i),
    .din_i({pc_q, instr_i}),
    .dout_o(head),
    .full_o(full),
    .empty_o(empty)
  );
endmodule

// File: tb/tb_rv_fetch_unit.sv
// tb_rv_fetch_unit: directed scenario checks for the fetch stage
module tb_rv_fetch_unit;
  logic clk = 0;
  logic rst = 1;
  logic [7:0] instr_addr_o;
  logic [31:0] instr_i;
  logic halt_i = 0, redirect_i = 0, if_ready_i = 0;
  logic [31:0] redirect_pc_i = 0;
  logic if_valid_o, fetch_busy_o;
  logic [31:0] if_instr_o, if_pc_o;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;
  assign instr_i = 32'h1000_0000 + {24'h0, instr_addr_o};

  rv_fetch_unit #(.DATA_WIDTH(32), .ROM_DEPTH(256), .FIFO_DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .instr_addr_o(instr_addr_o), .instr_i(instr_i),
    .halt_i(halt_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .if_valid_o(if_valid_o), .if_ready_i(if_ready_i), .if_instr_o(if_instr_o),
    .if_pc_o(if_pc_o), .fetch_busy_o(fetch_busy_o)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic rdy);
    @(posedge clk);
    #2;
    rst = 1; halt_i = 0; redirect_i = 0; redirect_pc_i = 0; if_ready_i = rdy;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    #1;
    checks++; if (if_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_valid_o); end
    checks++; if (if_pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", if_pc_o); end
    checks++; if (if_instr_o !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", if_instr_o); end
    checks++; if (instr_addr_o !== 8'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", instr_addr_o); end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++; if (if_valid_o !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, if_valid_o); end
      checks++; if (if_pc_o !== 32'(4*(k-1))) begin failures++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, if_pc_o, 32'(4*(k-1))); end
      checks++; if (if_instr_o !== 32'h1000_0000 + 32'(k-1)) begin failures++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, if_instr_o, 32'h1000_0000 + 32'(k-1)); end
      checks++; if (instr_addr_o !== 8'(k)) begin failures++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, instr_addr_o, 8'(k)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) tick();
    checks++; if (if_valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", if_valid_o); end
    checks++; if (if_pc_o !== 32'h0) begin failures++; $display("FAIL bp_head got=%h exp=0", if_pc_o); end
    checks++; if (instr_addr_o !== 8'd2) begin failures++; $display("FAIL bp_addr got=%h exp=2", instr_addr_o); end
    if_ready_i = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (if_pc_o !== exp_pc[k] || if_valid_o !== 1'b1) begin failures++; $display("FAIL bp_drain k=%0d got=%h/%b exp=%h/1", k, if_pc_o, if_valid_o, exp_pc[k]); end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) tick();
    checks++; if (instr_addr_o !== 8'h4) begin failures++; $display("FAIL redir_pre_addr got=%h exp=04", instr_addr_o); end
    redirect_i = 1; redirect_pc_i = 32'h0000_0043;
    tick();
    redirect_i = 0;
    #1;
    checks++; if (if_valid_o !== 1'b0) begin failures++; $display("FAIL redir_bubble got=%b exp=0", if_valid_o); end
    checks++; if (instr_addr_o !== 8'h10) begin failures++; $display("FAIL redir_addr got=%h exp=10", instr_addr_o); end
    tick();
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h40) begin failures++; $display("FAIL redir_target got=%h/%b exp=00000040/1", if_pc_o, if_valid_o); end
    checks++; if (if_instr_o !== 32'h1000_0010) begin failures++; $display("FAIL redir_instr got=%h exp=10000010", if_instr_o); end
    tick();
    checks++; if (if_pc_o !== 32'h44) begin failures++; $display("FAIL redir_next got=%h exp=00000044", if_pc_o); end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    tick();
    redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFE;
    tick();
    redirect_i = 0;
    #1;
    checks++; if (instr_addr_o !== 8'hFF) begin failures++; $display("FAIL wrap_addr got=%h exp=ff", instr_addr_o); end
    tick();
    checks++; if (if_pc_o !== 32'hFFFF_FFFC || if_instr_o !== 32'h1000_00FF) begin failures++; $display("FAIL wrap_top got=%h/%h exp=fffffffc/100000ff", if_pc_o, if_instr_o); end
    checks++; if (instr_addr_o !== 8'h0) begin failures++; $display("FAIL wrap_addr0 got=%h exp=00", instr_addr_o); end
    tick();
    checks++; if (if_pc_o !== 32'h0 || if_instr_o !== 32'h1000_0000) begin failures++; $display("FAIL wrap_zero got=%h/%h exp=00000000/10000000", if_pc_o, if_instr_o); end
  endtask

  task automatic test_halt();
    do_reset(1'b0);
    tick();
    tick();
    halt_i = 1; if_ready_i = 1;
    tick();
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h4) begin failures++; $display("FAIL halt_drain1 got=%h/%b exp=00000004/1", if_pc_o, if_valid_o); end
    tick();
    checks++; if (if_valid_o !== 1'b0) begin failures++; $display("FAIL halt_empty got=%b exp=0", if_valid_o); end
    tick();
    checks++; if (instr_addr_o !== 8'd2) begin failures++; $display("FAIL halt_addr got=%h exp=02", instr_addr_o); end
    checks++; if (fetch_busy_o !== 1'b0) begin failures++; $display("FAIL halt_busy got=%b exp=0", fetch_busy_o); end
    checks++; if (if_pc_o !== 32'h4) begin failures++; $display("FAIL halt_hold got=%h exp=00000004", if_pc_o); end
    halt_i = 0;
    tick();
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8) begin failures++; $display("FAIL halt_resume got=%h/%b exp=00000008/1", if_pc_o, if_valid_o); end
  endtask

  task automatic test_redirect_halt();
    do_reset(1'b1);
    tick();
    tick();
    redirect_i = 1; halt_i = 1; redirect_pc_i = 32'h80;
    tick();
    redirect_i = 0;
    #1;
    checks++; if (if_valid_o !== 1'b0 || instr_addr_o !== 8'h20) begin failures++; $display("FAIL rh_flush got=%b/%h exp=0/20", if_valid_o, instr_addr_o); end
    tick();
    checks++; if (if_valid_o !== 1'b0 || instr_addr_o !== 8'h20) begin failures++; $display("FAIL rh_hold got=%b/%h exp=0/20", if_valid_o, instr_addr_o); end
    halt_i = 0;
    tick();
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h80 || if_instr_o !== 32'h1000_0020) begin failures++; $display("FAIL rh_first got=%b/%h/%h exp=1/00000080/10000020", if_valid_o, if_pc_o, if_instr_o); end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    for (int k = 0; k < 3; k++) tick();
    checks++; if (if_pc_o !== 32'h8) begin failures++; $display("FAIL ar_pre got=%h exp=00000008", if_pc_o); end
    rst = 1;
    #1;
    checks++; if (if_valid_o !== 1'b0 || instr_addr_o !== 8'h0) begin failures++; $display("FAIL ar_immediate got=%b/%h exp=0/00", if_valid_o, instr_addr_o); end
    checks++; if (if_pc_o !== 32'h0) begin failures++; $display("FAIL ar_pc got=%h exp=0", if_pc_o); end
    tick();
    rst = 0;
    tick();
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || instr_addr_o !== 8'h1) begin failures++; $display("FAIL ar_restart got=%b/%h/%h exp=1/00000000/01", if_valid_o, if_pc_o, instr_addr_o); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_redirect_halt();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rv_fetch_unit.md
Name: rv_fetch_unit

Overview:
- Instruction-fetch stage between the instruction ROM and the rv_core decode stage.
- Owns the program counter and drives the ROM word address. The ROM is combinational, so the instruction word returns in the same cycle.
- Captures each (pc, instruction) pair into a small FIFO, presented to decode over a valid/ready handshake.
- Handles redirects (jump/branch) with a full flush, and supports fetch halt.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (32): instruction and PC width.
- ROM_DEPTH, `ROM_DEPTH: ROM words. AW = $clog2(ROM_DEPTH).
- FIFO_DEPTH, 2: fetch buffer entries. Must be a power of two, ≥2.
- RESET_PC, 32'h0000_0000: PC loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_addr_o  out  AW  ROM word address = pc_q[AW+1:2].
- instr_i  in  DATA_WIDTH  ROM read data for instr_addr_o, same cycle.
- halt_i  in  1  1 = suppress new fetches; buffered entries still drain.
- redirect_i  in  1  1 = flush buffer and load redirect_pc_i.
- redirect_pc_i  in  DATA_WIDTH  redirect target byte address.
- if_valid_o  out  1  buffer head valid.
- if_ready_i  in  1  decode accepts head this cycle.
- if_instr_o  out  DATA_WIDTH  head instruction.
- if_pc_o  out  DATA_WIDTH  head byte PC.
- fetch_busy_o  out  1  buffer non-empty, or fetch enabled and not halted.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - pc_q = RESET_PC, buffer empty, if_valid_o = 0.
  - if_instr_o = 0, if_pc_o = 0.
  - instr_addr_o = RESET_PC[AW+1:2].
- Pop: pop = if_valid_o & if_ready_i.
- Push: push = ~halt_i & ~redirect_i & (~full | pop). Push writes {pc_q, instr_i} at tail and sets pc_q <= pc_q + 4.
  - The add is modulo 2^DATA_WIDTH; wrap 32'hFFFF_FFFC -> 0.
  - instr_addr_o is a truncation, so ROM index wrap is implicit.
- Full with pop in the same cycle: push still occurs. Sustained throughput is 1 instruction/cycle.
- Empty with push in the same cycle: no bypass. The entry appears at the head next cycle.
  - First if_valid_o = 1 is one cycle after reset deasserts.
- Redirect has highest priority:
  - Next edge: buffer cleared (head/tail/count reset), pc_q <= {redirect_pc_i[31:2], 2'b00}.
  - Any push and pop that cycle are discarded. Low 2 bits of the target are ignored (no misalign trap).
  - if_valid_o = 0 the cycle after redirect. The first target instruction is valid the cycle after that: 2-cycle redirect bubble.
- Redirect while halt_i = 1: PC is still updated and the buffer flushed; no fetch until halt_i drops.
- halt_i: the PC holds and no push occurs. Pops continue until empty; if_valid_o then falls.
- Outputs: if_instr_o / if_pc_o come from the head register. When if_valid_o = 0 they hold the last head value; decode must not sample them.
- Head stability: while if_valid_o = 1 and if_ready_i = 0, if_instr_o and if_pc_o are stable.
- Counter width: count is $clog2(FIFO_DEPTH)+1 bits. full = (count == FIFO_DEPTH), empty = (count == 0). Pointers wrap at FIFO_DEPTH.
- No combinational path from if_ready_i to instr_addr_o. A path from if_ready_i to push enable is permitted.
- Reset mid-operation: returns immediately to reset state, and all buffered entries are lost.

Decomposition:
- defines.v additions:
  - `RESET_PC
  - `FETCH_DEPTH (2)
  - `INSTR_NOP (32'h0000_0013) for future flush fill
- defines.v existing: `DATA_WIDTH, `ROM_DEPTH.
- One sub-module: rv_fetch_fifo.
  - Generic synchronous FIFO: WIDTH = 2*DATA_WIDTH, DEPTH = FIFO_DEPTH.
  - Ports: push/pop/flush, full/empty, head data.
  - Async active-high reset.
- rv_fetch_unit holds the PC register, the push/redirect control and the address slice.

Test Plan:
- Reset release, ROM word n = 32'h1000_0000+n, if_ready_i = 1 -> instr_addr_o 0,1,2,… each cycle. if_valid_o high from cycle 1; if_pc_o = 0,4,8,… and if_instr_o = 32'h1000_0000,…01,… with no gaps.
- if_ready_i = 0 from start -> two pushes (pc 0,4), then instr_addr_o holds at 2. if_valid_o stays 1, head = pc 0. Raise ready -> drains pc 0,4,8 consecutively.
- Redirect to 32'h0000_0043 at pc 0x10 with ready = 1 -> pc_q = 0x40, if_valid_o = 0 for one cycle, then if_pc_o = 0x40. No 0x10/0x14 entry is ever accepted after the flush.
- halt_i = 1 with 2 entries buffered, ready = 1 -> both drain, then if_valid_o = 0 and instr_addr_o frozen. Deassert halt -> fetch resumes at the next sequential PC.
- Redirect asserted together with halt_i and pop -> buffer empties, pc_q loads target, no fetch while halted. Release halt -> first entry is the target PC.
- rst pulsed asynchronously mid-stream (between edges) -> if_valid_o drops immediately, instr_addr_o = 0. After release the sequence restarts from pc 0.
